// File: rtl/adler32_checker.sv
// Streaming Adler-32 checker: accumulates A/B over a payload frame, then collects
// four trailing checksum bytes and reports a one-cycle verdict pulse.
//
// state   | meaning
// PAYLOAD | accumulating A/B over payload bytes until last_data
// CKSUM   | collecting the four received checksum bytes
module adler32_checker #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        data_valid,
   input  logic [7:0]  data,
   input  logic        last_data,
   output logic        busy,
   output logic        check_valid,
   output logic        check_pass,
   output logic [31:0] calc_checksum,
   output logic [31:0] rx_checksum
);

   localparam logic [16:0] ADLER_MOD = 17'd65521;

   typedef enum logic {
      PAYLOAD = 1'b0,
      CKSUM   = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] sum_a;
   logic [15:0] sum_b;
   logic [1:0]  byte_cnt;
   logic [31:0] rx_reg;

   logic [16:0] a_raw;
   logic [16:0] b_raw;
   logic [15:0] a_next;
   logic [15:0] b_next;
   logic [31:0] rx_next;
   logic [31:0] calc_now;

   // Both sums stay below 2*65521, so one conditional subtract is a full reduction.
   always_comb begin
      a_raw  = {1'b0, sum_a} + {9'd0, data};
      a_next = (a_raw >= ADLER_MOD) ? 16'(a_raw - ADLER_MOD) : a_raw[15:0];
      b_raw  = {1'b0, sum_b} + {1'b0, a_next};
      b_next = (b_raw >= ADLER_MOD) ? 16'(b_raw - ADLER_MOD) : b_raw[15:0];
   end

   always_comb begin
      rx_next = rx_reg;
      if (MSB_FIRST) begin
         case (byte_cnt)
            2'd0:    rx_next[31:24] = data;
            2'd1:    rx_next[23:16] = data;
            2'd2:    rx_next[15:8]  = data;
            default: rx_next[7:0]   = data;
         endcase
      end else begin
         case (byte_cnt)
            2'd0:    rx_next[7:0]   = data;
            2'd1:    rx_next[15:8]  = data;
            2'd2:    rx_next[23:16] = data;
            default: rx_next[31:24] = data;
         endcase
      end
   end

   assign calc_now = {sum_b, sum_a};
   assign busy     = (state == CKSUM);

   always_ff @(posedge clock) begin
      if (rst) begin
         state         <= PAYLOAD;
         sum_a         <= 16'd1;
         sum_b         <= 16'd0;
         byte_cnt      <= 2'd0;
         rx_reg        <= 32'd0;
         check_valid   <= 1'b0;
         check_pass    <= 1'b0;
         calc_checksum <= 32'h0000_0001;
         rx_checksum   <= 32'd0;
      end else begin
         check_valid <= 1'b0;
         case (state)
            PAYLOAD: begin
               if (data_valid) begin
                  sum_a <= a_next;
                  sum_b <= b_next;
                  if (last_data) begin
                     state    <= CKSUM;
                     byte_cnt <= 2'd0;
                  end
               end
            end
            CKSUM: begin
               if (data_valid) begin
                  if (byte_cnt == 2'd3) begin
                     // Verdict uses the fully assembled word including this byte.
                     check_valid   <= 1'b1;
                     rx_checksum   <= rx_next;
                     calc_checksum <= calc_now;
                     check_pass    <= (rx_next == calc_now);
                     sum_a         <= 16'd1;
                     sum_b         <= 16'd0;
                     byte_cnt      <= 2'd0;
                     rx_reg        <= 32'd0;
                     state         <= PAYLOAD;
                  end else begin
                     rx_reg   <= rx_next;
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
